// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//   Command-side master for the 8-bit combinational ALU. Accepts one
//   (func, a, b, tag) command at a time on a valid/ready channel, drives the
//   operands onto the ALU for one full cycle, captures the result and returns
//   it with an operand-derived error flag on a valid/ready response channel.
//   Sequence per command: IDLE (accept) -> DRIVE (ALU settles) -> RESP (hold).
//
// Optional feature macro: ALU_ISSUE_STATS_EN
//   When defined, adds saturating completed/errored command counters and the
//   i_stat_clr / o_stat_ops / o_stat_errs ports plus the STAT_W parameter.
//
// Parameters
//   TAG_W         command tag width, echoed unchanged on the response
//   STAT_W        statistics counter width (ALU_ISSUE_STATS_EN only)
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous reset, active-high
//   i_cmd_valid   command valid
//   o_cmd_ready   command ready (registered)
//   i_cmd_func    ALU function code
//   i_cmd_a       operand A
//   i_cmd_b       operand B
//   i_cmd_tag     command tag
//   o_alu_a       operand A to the ALU (registered)
//   o_alu_b       operand B to the ALU (registered)
//   o_alu_func    function code to the ALU (registered)
//   i_alu_result  combinational ALU result
//   o_rsp_valid   response valid
//   i_rsp_ready   response ready
//   o_rsp_data    captured ALU result
//   o_rsp_err     command-level error flag
//   o_rsp_tag     tag of the completed command
//   i_stat_clr    clear statistics             (ALU_ISSUE_STATS_EN only)
//   o_stat_ops    completed-command count      (ALU_ISSUE_STATS_EN only)
//   o_stat_errs   errored-command count        (ALU_ISSUE_STATS_EN only)
// -----------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int unsigned TAG_W  = 4
`ifdef ALU_ISSUE_STATS_EN
  ,parameter int unsigned STAT_W = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [3:0]        i_cmd_func,
  input  logic [7:0]        i_cmd_a,
  input  logic [7:0]        i_cmd_b,
  input  logic [TAG_W-1:0]  i_cmd_tag,
  output logic [7:0]        o_alu_a,
  output logic [7:0]        o_alu_b,
  output logic [3:0]        o_alu_func,
  input  logic [7:0]        i_alu_result,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [7:0]        o_rsp_data,
  output logic              o_rsp_err,
  output logic [TAG_W-1:0]  o_rsp_tag
`ifdef ALU_ISSUE_STATS_EN
  ,input  logic              i_stat_clr
  ,output logic [STAT_W-1:0] o_stat_ops
  ,output logic [STAT_W-1:0] o_stat_errs
`endif
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned SUM_W  = DATA_W + 1;

  localparam logic [FUNC_W-1:0] FN_ADD = 4'b0010;
  localparam logic [FUNC_W-1:0] FN_SUB = 4'b0011;
  localparam logic [FUNC_W-1:0] FN_SH0 = 4'b0100;
  localparam logic [FUNC_W-1:0] FN_SH1 = 4'b0101;
  localparam logic [FUNC_W-1:0] FN_SH2 = 4'b0110;
  localparam logic [DATA_W-1:0] SHIFT_LIMIT = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0]   alu_a_q,     alu_a_d;
  logic [DATA_W-1:0]   alu_b_q,     alu_b_d;
  logic [FUNC_W-1:0]   alu_func_q,  alu_func_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic                rsp_err_q,   rsp_err_d;
  logic [TAG_W-1:0]    rsp_tag_q,   rsp_tag_d;

  logic                cmd_fire_c;
  logic                rsp_fire_c;
  logic                cmd_err_c;
  logic [SUM_W-1:0]    sum_c;

`ifdef ALU_ISSUE_STATS_EN
  logic [STAT_W-1:0]   stat_ops_q,  stat_ops_d;
  logic [STAT_W-1:0]   stat_errs_q, stat_errs_d;
`endif

  // Handshake qualifiers; ready is registered so accepts only happen in IDLE.
  assign cmd_fire_c = i_cmd_valid & cmd_ready_q & (state_q == ST_IDLE);
  assign rsp_fire_c = rsp_valid_q & i_rsp_ready & (state_q == ST_RESP);

  // Error flag derived from the operands only, never from the ALU result
  // (the ALU's 8'hEE error code is also a legal data value).
  always_comb begin
    sum_c     = SUM_W'(i_cmd_a) + SUM_W'(i_cmd_b);
    cmd_err_c = 1'b0;
    case (i_cmd_func)
      FN_ADD:                 cmd_err_c = sum_c[SUM_W-1];
      FN_SUB:                 cmd_err_c = (i_cmd_a < i_cmd_b);
      FN_SH0, FN_SH1, FN_SH2: cmd_err_c = (i_cmd_b >= SHIFT_LIMIT);
      default:                cmd_err_c = 1'b0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_tag_d   = rsp_tag_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_c) begin
          alu_a_d    = i_cmd_a;
          alu_b_d    = i_cmd_b;
          alu_func_d = i_cmd_func;
          rsp_tag_d  = i_cmd_tag;
          rsp_err_d  = cmd_err_c;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // ALU inputs have been stable for this whole cycle.
        rsp_data_d  = i_alu_result;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire_c) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // No bypass: ready follows the state we are about to enter.
    cmd_ready_d = (state_d == ST_IDLE);
  end

`ifdef ALU_ISSUE_STATS_EN
  // Saturating counters; clear beats a same-cycle increment.
  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
    if (i_stat_clr) begin
      stat_ops_d  = '0;
      stat_errs_d = '0;
    end else if (rsp_fire_c) begin
      if (~&stat_ops_q) begin
        stat_ops_d = stat_ops_q + STAT_W'(1);
      end
      if (rsp_err_q && (~&stat_errs_q)) begin
        stat_errs_d = stat_errs_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign o_stat_ops  = stat_ops_q;
  assign o_stat_errs = stat_errs_q;
`else
  // Statistics hardware is not built in this configuration.
`endif

  // State and output registers; reset discards any in-flight command.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_alu_a     = alu_a_q;
  assign o_alu_b     = alu_b_q;
  assign o_alu_func  = alu_func_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issuer
//   Directed bench for alu_cmd_issuer with a behavioural ALU attached to the
//   issuer's operand outputs. Define ALU_ISSUE_STATS_EN to also exercise the
//   statistics counters (instantiated with STAT_W=2).
// -----------------------------------------------------------------------------
module tb_alu_cmd_issuer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_func;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_tag;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_func;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] rsp_tag;
`ifdef ALU_ISSUE_STATS_EN
  logic       stat_clr;
  logic [1:0] stat_ops;
  logic [1:0] stat_errs;
`endif

  int n_chk = 0;
  int n_err = 0;

`ifdef ALU_ISSUE_STATS_EN
  alu_cmd_issuer #(.TAG_W(4), .STAT_W(2)) dut (
`else
  alu_cmd_issuer #(.TAG_W(4)) dut (
`endif
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_func   (cmd_func),
    .i_cmd_a      (cmd_a),
    .i_cmd_b      (cmd_b),
    .i_cmd_tag    (cmd_tag),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_func   (alu_func),
    .i_alu_result (alu_result),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_rsp_tag    (rsp_tag)
`ifdef ALU_ISSUE_STATS_EN
    ,.i_stat_clr  (stat_clr)
    ,.o_stat_ops  (stat_ops)
    ,.o_stat_errs (stat_errs)
`endif
  );

  // Behavioural 8-bit ALU; returns 8'hEE as its error code.
  always_comb begin
    logic [8:0] s;
    s = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_func)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = s[8] ? 8'hEE : s[7:0];
      4'b0011: alu_result = (alu_a < alu_b) ? 8'hEE : (alu_a - alu_b);
      4'b0100: alu_result = (alu_b >= 8'd8) ? 8'hEE : (alu_a << alu_b[2:0]);
      4'b0101: alu_result = (alu_b >= 8'd8) ? 8'hEE : (alu_a >> alu_b[2:0]);
      4'b0110: alu_result = (alu_b >= 8'd8) ? 8'hEE : 8'((alu_a << alu_b[2:0]) | (alu_a >> (4'd8 - {1'b0, alu_b[2:0]})));
      4'b1011: alu_result = {alu_a[6:0], 1'b0};
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Issue one command, check ALU drive, response, and handshake turnaround.
  task automatic do_cmd(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] t, input logic [7:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    while (!cmd_ready && n < 10) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b; cmd_tag = t;
    tick();
    cmd_valid = 1'b0;
    chk("alu_a", 16'(alu_a), 16'(a));
    chk("alu_b", 16'(alu_b), 16'(b));
    chk("alu_func", 16'(alu_func), 16'(f));
    chk("drive_ready", 16'(cmd_ready), 16'd0);
    chk("drive_rsp_valid", 16'(rsp_valid), 16'd0);
    tick();
    chk("rsp_valid", 16'(rsp_valid), 16'd1);
    chk("rsp_data", 16'(rsp_data), 16'(exp_d));
    chk("rsp_err", 16'(rsp_err), 16'(exp_e));
    chk("rsp_tag", 16'(rsp_tag), 16'(t));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_hs_valid", 16'(rsp_valid), 16'd0);
    chk("post_hs_ready", 16'(cmd_ready), 16'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_func = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_tag = 4'h0;
`ifdef ALU_ISSUE_STATS_EN
    stat_clr = 1'b0;
`endif
    // Reset with a command offered; it must be ignored.
    cmd_valid = 1'b1; cmd_func = 4'h1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_tag = 4'h7;
    tick();
    tick();
    chk("rst_ready", 16'(cmd_ready), 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    chk("rst_alu_b", 16'(alu_b), 16'd0);
    chk("rst_alu_func", 16'(alu_func), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_data", 16'(rsp_data), 16'd0);
    chk("rst_rsp_err", 16'(rsp_err), 16'd0);
    chk("rst_rsp_tag", 16'(rsp_tag), 16'd0);
    rst = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("rel_ready", 16'(cmd_ready), 16'd1);
    chk("rel_no_accept", 16'(alu_a), 16'd0);
`ifdef ALU_ISSUE_STATS_EN
    chk("rst_stat_ops", 16'(stat_ops), 16'd0);
    chk("rst_stat_errs", 16'(stat_errs), 16'd0);
`endif

    // Main function with hand-computed results.
    do_cmd(4'b0000, 8'hF0, 8'h3C, 4'd3, 8'h30, 1'b0);
    do_cmd(4'b0010, 8'hC8, 8'h64, 4'd5, 8'hEE, 1'b1);
    do_cmd(4'b0011, 8'hF0, 8'h02, 4'd6, 8'hEE, 1'b0);
    do_cmd(4'b0101, 8'h80, 8'd9,  4'd7, 8'hEE, 1'b1);
    do_cmd(4'b1011, 8'h10, 8'h08, 4'd8, 8'h20, 1'b0);
    // Error-flag boundaries.
    do_cmd(4'b0010, 8'hFF, 8'h01, 4'd1, 8'hEE, 1'b1);
    do_cmd(4'b0010, 8'hFE, 8'h01, 4'd2, 8'hFF, 1'b0);
    do_cmd(4'b0011, 8'h05, 8'h05, 4'd4, 8'h00, 1'b0);
    do_cmd(4'b0100, 8'h01, 8'h07, 4'd9, 8'h80, 1'b0);
    do_cmd(4'b0110, 8'h01, 8'h08, 4'hA, 8'hEE, 1'b1);
    do_cmd(4'b0110, 8'h81, 8'h01, 4'hB, 8'h03, 1'b0);

    // Response backpressure: outputs held, no new command accepted.
    cmd_valid = 1'b1; cmd_func = 4'b0010; cmd_a = 8'hC8; cmd_b = 8'h64; cmd_tag = 4'hC;
    tick();
    cmd_func = 4'b0000; cmd_a = 8'h11; cmd_tag = 4'h1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 16'(rsp_valid), 16'd1);
      chk("bp_data", 16'(rsp_data), 16'hEE);
      chk("bp_err", 16'(rsp_err), 16'd1);
      chk("bp_tag", 16'(rsp_tag), 16'hC);
      chk("bp_ready", 16'(cmd_ready), 16'd0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("hs_same_cycle_ready", 16'(cmd_ready), 16'd0);
    tick();
    rsp_ready = 1'b0;
    chk("hs_next_ready", 16'(cmd_ready), 16'd1);
    chk("hs_valid_low", 16'(rsp_valid), 16'd0);
    chk("bp_alu_kept", 16'(alu_a), 16'hC8);

    // Reset while in DRIVE discards the command.
    cmd_valid = 1'b1; cmd_func = 4'b0010; cmd_a = 8'hFF; cmd_b = 8'h01; cmd_tag = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("pre_rst_alu_a", 16'(alu_a), 16'hFF);
    rst = 1'b1;
    tick();
    chk("drst_ready", 16'(cmd_ready), 16'd0);
    chk("drst_alu_a", 16'(alu_a), 16'd0);
    chk("drst_alu_b", 16'(alu_b), 16'd0);
    chk("drst_alu_func", 16'(alu_func), 16'd0);
    chk("drst_valid", 16'(rsp_valid), 16'd0);
    chk("drst_err", 16'(rsp_err), 16'd0);
    chk("drst_tag", 16'(rsp_tag), 16'd0);
    chk("drst_data", 16'(rsp_data), 16'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("drst_rel_ready", 16'(cmd_ready), 16'd1);
    chk("drst_no_rsp", 16'(rsp_valid), 16'd0);
    tick();
    chk("drst_no_rsp2", 16'(rsp_valid), 16'd0);
    rsp_ready = 1'b0;

`ifdef ALU_ISSUE_STATS_EN
    // Saturating counters with STAT_W=2.
    do_cmd(4'b0010, 8'hC8, 8'h64, 4'd1, 8'hEE, 1'b1);
    do_cmd(4'b0000, 8'hF0, 8'h3C, 4'd2, 8'h30, 1'b0);
    chk("stat_ops_2", 16'(stat_ops), 16'd2);
    chk("stat_errs_1", 16'(stat_errs), 16'd1);
    do_cmd(4'b0101, 8'h80, 8'd9,  4'd3, 8'hEE, 1'b1);
    do_cmd(4'b1011, 8'h10, 8'h08, 4'd4, 8'h20, 1'b0);
    do_cmd(4'b0011, 8'hF0, 8'h02, 4'd5, 8'hEE, 1'b0);
    chk("stat_ops_sat", 16'(stat_ops), 16'd3);
    chk("stat_errs_2", 16'(stat_errs), 16'd2);
    // Clear coinciding with a completing handshake.
    cmd_valid = 1'b1; cmd_func = 4'b0010; cmd_a = 8'hFF; cmd_b = 8'h01; cmd_tag = 4'd6;
    tick();
    cmd_valid = 1'b0;
    tick();
    rsp_ready = 1'b1; stat_clr = 1'b1;
    tick();
    rsp_ready = 1'b0; stat_clr = 1'b0;
    chk("clr_ops", 16'(stat_ops), 16'd0);
    chk("clr_errs", 16'(stat_errs), 16'd0);
    do_cmd(4'b0010, 8'hFF, 8'h01, 4'd7, 8'hEE, 1'b1);
    chk("post_clr_ops", 16'(stat_ops), 16'd1);
    chk("post_clr_errs", 16'(stat_errs), 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
